// File: rtl/mc10_vram_arbiter_if.sv
// CPU-side request/acknowledge bus of the MC-10 video RAM arbiter.
// The CPU drives the master modport; the arbiter takes the slave modport.
interface mc10_vram_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata
  );
endinterface

// File: rtl/mc10_vram_arbiter.sv
// Time-slot arbiter for the MC-10 video RAM: fixed 2-cycle VDG window per period,
// CPU reads/writes in the remaining cycles through a req/ack handshake.
//
// state | meaning
// IDLE  | waiting for cpu_req while the next phase is outside the VDG window
// ACC   | CPU address/write data on the RAM port (write commits at end of cycle)
// RDW   | RAM read data valid on ram_dout, captured into cpu_rdata
// ACK   | single-cycle cpu_ack pulse; cpu_req ignored
module mc10_vram_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8,
  parameter int PERIOD = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_W-1:0]     vdg_addr,
  output logic                  vdg_ms,
  output logic [DATA_W-1:0]     vdg_dd,
  mc10_vram_arbiter_if.slave    cpu,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic                  ram_we,
  output logic [DATA_W-1:0]     ram_din,
  input  logic [DATA_W-1:0]     ram_dout
);

  localparam int P_W = $clog2(PERIOD);
  localparam logic [P_W-1:0] P_LAST = P_W'(PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RDW  = 2'd2,
    ACK  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [P_W-1:0]    p_q, p_d;
  logic              vdg_win_d;
  logic              vdg_ms_q, vdg_ms_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_we_q, ram_we_d;
  logic [DATA_W-1:0] ram_din_q, ram_din_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      p_q         <= P_LAST;
      vdg_ms_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_din_q   <= '0;
      cpu_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      p_q         <= p_d;
      vdg_ms_q    <= vdg_ms_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_din_q   <= ram_din_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
    end
  end

  // Registered outputs are decoded from the next phase so they line up with p_q.
  always_comb begin
    p_d         = (p_q == P_LAST) ? '0 : p_q + P_W'(1);
    vdg_win_d   = (p_d < P_W'(2));
    state_d     = state_q;
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_din_d   = ram_din_q;
    cpu_rdata_d = cpu_rdata_q;

    unique case (state_q)
      IDLE:    if (cpu.cpu_req && !vdg_win_d) state_d = ACC;
      ACC:     state_d = cpu.cpu_we ? ACK : RDW;
      RDW:     state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (vdg_win_d) begin
      ram_addr_d = vdg_addr;
    end else if (state_d == ACC) begin
      ram_addr_d = cpu.cpu_addr;
      ram_we_d   = cpu.cpu_we;
      ram_din_d  = cpu.cpu_wdata;
    end

    // RDW may sit in phase 0: ram_dout still carries the CPU address data then.
    if (state_q == RDW) cpu_rdata_d = ram_dout;

    vdg_ms_d  = vdg_win_d;
    cpu_ack_d = (state_d == ACK);
  end

  assign vdg_ms        = vdg_ms_q;
  assign vdg_dd        = ram_dout;
  assign ram_addr      = ram_addr_q;
  assign ram_we        = ram_we_q;
  assign ram_din       = ram_din_q;
  assign cpu.cpu_ack   = cpu_ack_q;
  assign cpu.cpu_rdata = cpu_rdata_q;

  // The VDG window must never carry a write.
  a_no_we_in_vdg: assert property (@(posedge clk) disable iff (!reset_n)
                                   !(ram_we_q && vdg_ms_q));

endmodule

// File: tb/tb_mc10_vram_arbiter.sv
// Self-checking bench for mc10_vram_arbiter (PERIOD=8): directed phase scenarios
// plus randomized CPU traffic against a phase-arithmetic and shadow-memory model.
module tb_mc10_vram_arbiter;

  localparam int AW = 13;
  localparam int DW = 8;
  localparam int PER = 8;

  logic          clk;
  logic          reset_n;
  logic [AW-1:0] vdg_addr;
  logic          vdg_ms;
  logic [DW-1:0] vdg_dd;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  mc10_vram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) cpu_if ();

  mc10_vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PERIOD(PER)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .vdg_addr (vdg_addr),
    .vdg_ms   (vdg_ms),
    .vdg_dd   (vdg_dd),
    .cpu      (cpu_if),
    .ram_addr (ram_addr),
    .ram_we   (ram_we),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous RAM, read-first, 1-cycle latency.
  logic [DW-1:0] ram_mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_din;
    ram_dout <= ram_mem[ram_addr];
  end

  logic [DW-1:0] shadow [0:(1<<AW)-1];
  int            n_chk = 0;
  int            n_err = 0;
  int            cyc = 0;
  int            exp_we_cyc = -1;
  int            exp_ack_cyc = -1;
  bit            in_rst = 1'b1;
  bit            vdg_rand = 1'b1;
  logic [AW-1:0] vdg_fix = '0;
  logic [AW-1:0] vdg_at_edge = '0;
  logic [AW-1:0] addr_ph0 = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock; cycle cyc (counted from reset release) is in phase (cyc-1) mod PER.
  task automatic tick();
    int ph;
    @(posedge clk);
    vdg_at_edge = vdg_addr;
    cyc++;
    @(negedge clk);
    if (!in_rst) begin
      ph = (cyc - 1) % PER;
      check("vdg_ms", 32'(vdg_ms), 32'(ph < 2));
      check("ram_we", 32'(ram_we), 32'(cyc == exp_we_cyc));
      check("cpu_ack", 32'(cpu_if.cpu_ack), 32'(cyc == exp_ack_cyc));
      if (ph == 0) begin
        check("ram_addr_vdg0", 32'(ram_addr), 32'(vdg_at_edge));
        addr_ph0 = vdg_at_edge;
      end
      if (ph == 1) begin
        check("ram_addr_vdg1", 32'(ram_addr), 32'(vdg_at_edge));
        check("vdg_dd", 32'(vdg_dd), 32'(shadow[addr_ph0]));
      end
    end
    vdg_addr = vdg_rand ? AW'($urandom) : vdg_fix;
  endtask

  task automatic wait_phase(input int target);
    for (int i = 0; i < PER && ((cyc - 1) % PER) != target; i++) tick();
  endtask

  // Accepted at the first edge whose next phase is >= 2; ACC, then RDW for reads, then ACK.
  task automatic cpu_access(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    int pn, acc;
    cpu_if.cpu_req   = 1'b1;
    cpu_if.cpu_we    = we;
    cpu_if.cpu_addr  = addr;
    cpu_if.cpu_wdata = wd;
    pn  = cyc % PER;
    acc = (pn >= 2) ? cyc + 1 : cyc + 1 + (2 - pn);
    exp_we_cyc  = we ? acc : -1;
    exp_ack_cyc = we ? acc + 1 : acc + 2;
    while (cyc < exp_ack_cyc) begin
      tick();
      if (cyc == acc) begin
        check("acc_addr", 32'(ram_addr), 32'(addr));
        if (we) begin
          check("acc_din", 32'(ram_din), 32'(wd));
          shadow[addr] = wd;
        end
      end
    end
    if (!we) check("cpu_rdata", 32'(cpu_if.cpu_rdata), 32'(shadow[addr]));
    cpu_if.cpu_req = 1'b0;
    exp_we_cyc  = -1;
    exp_ack_cyc = -1;
  endtask

  logic [AW-1:0] pool [8];

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      ram_mem[i] = DW'(i) ^ 8'h3C;
      shadow[i]  = DW'(i) ^ 8'h3C;
    end
    reset_n          = 1'b0;
    vdg_addr         = '0;
    cpu_if.cpu_req   = 1'b0;
    cpu_if.cpu_we    = 1'b0;
    cpu_if.cpu_addr  = '0;
    cpu_if.cpu_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_vdg_ms", 32'(vdg_ms), 32'h0);
    check("rst_ram_we", 32'(ram_we), 32'h0);
    check("rst_ram_addr", 32'(ram_addr), 32'h0);
    check("rst_cpu_ack", 32'(cpu_if.cpu_ack), 32'h0);
    check("rst_cpu_rdata", 32'(cpu_if.cpu_rdata), 32'h0);
    reset_n = 1'b1;
    in_rst  = 1'b0;
    cyc     = 0;

    // Idle traffic: VDG windows only.
    repeat (2 * PER) tick();

    // VDG fetch of a preloaded location.
    ram_mem[13'h0123] = 8'h5A;
    shadow[13'h0123]  = 8'h5A;
    vdg_rand = 1'b0;
    vdg_fix  = 13'h0123;
    vdg_addr = vdg_fix;
    wait_phase(7);
    tick();
    tick();
    check("vdg_dd_5a", 32'(vdg_dd), 32'h5A);
    vdg_rand = 1'b1;

    // Write raised at next phase 3, read back, then reads straddling the VDG window.
    wait_phase(2);
    cpu_access(1'b1, 13'h1F00, 8'hA5);
    tick();
    cpu_access(1'b0, 13'h1F00, 8'h00);
    wait_phase(7);
    cpu_access(1'b0, 13'h0123, 8'h00);
    vdg_rand = 1'b0;
    vdg_fix  = 13'h0777;
    wait_phase(6);
    cpu_access(1'b0, 13'h1F00, 8'h00);
    vdg_rand = 1'b1;
    repeat (PER) tick();

    // Reset during the ACC cycle of a write.
    wait_phase(3);
    cpu_if.cpu_req   = 1'b1;
    cpu_if.cpu_we    = 1'b1;
    cpu_if.cpu_addr  = 13'h0AAA;
    cpu_if.cpu_wdata = 8'h77;
    exp_we_cyc = cyc + 1;
    tick();
    reset_n = 1'b0;
    in_rst  = 1'b1;
    #1;
    check("mid_rst_vdg_ms", 32'(vdg_ms), 32'h0);
    check("mid_rst_ram_we", 32'(ram_we), 32'h0);
    check("mid_rst_ram_addr", 32'(ram_addr), 32'h0);
    check("mid_rst_ram_din", 32'(ram_din), 32'h0);
    check("mid_rst_cpu_ack", 32'(cpu_if.cpu_ack), 32'h0);
    check("mid_rst_cpu_rdata", 32'(cpu_if.cpu_rdata), 32'h0);
    cpu_if.cpu_req = 1'b0;
    exp_we_cyc = -1;
    repeat (2) tick();
    reset_n = 1'b1;
    in_rst  = 1'b0;
    cyc     = 0;
    repeat (PER) tick();
    cpu_access(1'b0, 13'h0AAA, 8'h00);

    // Randomized traffic over a small address pool so reads hit earlier writes.
    for (int i = 0; i < 8; i++) pool[i] = AW'($urandom);
    pool[0] = 13'h1F00;
    for (int t = 0; t < 80; t++) begin
      int gap;
      gap = int'($urandom_range(1, 9));
      repeat (gap) tick();
      cpu_access(1'($urandom), pool[$urandom_range(0, 7)], DW'($urandom));
    end
    repeat (PER) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
